// File: rtl/counter_mod.sv
// Modulo-MODULUS counter with parallel load, edge-detected set buttons, a carry pulse and an at_max flag.
// Defining COUNTER_MOD_DOWN_EN adds the setting_down button.
module counter_mod #(
  parameter int MODULUS = 24,
  parameter int WIDTH   = 6,
  parameter int INIT    = 0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic             data_valid,
  input  logic [WIDTH-1:0] data,
  input  logic             setting_up,
`ifdef COUNTER_MOD_DOWN_EN
  input  logic             setting_down,
`endif
  output logic [WIDTH-1:0] count,
  output logic             carry,
  output logic             at_max
);

  // One extra bit so MODULUS == 2**WIDTH is representable in range compares.
  localparam logic [WIDTH:0]   MOD_EXT  = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MAX_VAL  = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH-1:0] INIT_VAL = WIDTH'(INIT);

  logic             up_q;
  logic             up_edge;
  logic             dn_edge;
  logic             data_ok;
  logic             count_ok;
  logic [WIDTH-1:0] count_nxt;
  logic             carry_nxt;

  assign up_edge  = setting_up & ~up_q;
  assign data_ok  = {1'b0, data}  < MOD_EXT;
  assign count_ok = {1'b0, count} < MOD_EXT;
  assign at_max   = (count == MAX_VAL);

`ifdef COUNTER_MOD_DOWN_EN
  logic dn_q;
  assign dn_edge = setting_down & ~dn_q;

  always_ff @(posedge clock) begin
    if (reset) dn_q <= 1'b0;
    else       dn_q <= setting_down;
  end
`else
  assign dn_edge = 1'b0;
`endif

  // Set-mode actions never raise carry, so adjusting a field never ripples downstream.
  always_comb begin
    count_nxt = count;
    carry_nxt = 1'b0;
    if (load) begin
      if (data_valid)   count_nxt = data_ok ? data : MAX_VAL;
      else if (up_edge) count_nxt = at_max ? '0 : count + WIDTH'(1);
      else if (dn_edge) count_nxt = (count == '0) ? MAX_VAL : count - WIDTH'(1);
    end else if (!count_ok) begin
      count_nxt = '0;
    end else if (enable) begin
      if (at_max) begin
        count_nxt = '0;
        carry_nxt = 1'b1;
      end else begin
        count_nxt = count + WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= INIT_VAL;
      carry <= 1'b0;
      up_q  <= 1'b0;
    end else begin
      count <= count_nxt;
      carry <= carry_nxt;
      up_q  <= setting_up;
    end
  end

endmodule

// File: tb/tb_counter_mod.sv
// Self-checking bench for counter_mod: three instances (mod 24, 60 with INIT 7, 64) driven in parallel
// and compared against a behavioural model of the counting and set-mode rules.
module tb_counter_mod;

  logic       clock = 1'b0;
  logic       reset, enable, load, data_valid, setting_up, setting_down;
  logic [5:0] data;
  logic [5:0] cnt_o [3];
  logic       car_o [3];
  logic       max_o [3];

  int n_checks = 0;
  int n_fail   = 0;

  int mods  [3] = '{24, 60, 64};
  int inits [3] = '{0, 7, 0};
  int m_cnt [3];
  int m_car [3];
  int m_upp [3];
  int m_dnp [3];

  always #5 clock = ~clock;

  counter_mod #(.MODULUS(24), .WIDTH(6), .INIT(0)) u24 (
    .clock(clock), .reset(reset), .enable(enable), .load(load), .data_valid(data_valid),
    .data(data), .setting_up(setting_up),
`ifdef COUNTER_MOD_DOWN_EN
    .setting_down(setting_down),
`endif
    .count(cnt_o[0]), .carry(car_o[0]), .at_max(max_o[0]));

  counter_mod #(.MODULUS(60), .WIDTH(6), .INIT(7)) u60 (
    .clock(clock), .reset(reset), .enable(enable), .load(load), .data_valid(data_valid),
    .data(data), .setting_up(setting_up),
`ifdef COUNTER_MOD_DOWN_EN
    .setting_down(setting_down),
`endif
    .count(cnt_o[1]), .carry(car_o[1]), .at_max(max_o[1]));

  counter_mod #(.MODULUS(64), .WIDTH(6), .INIT(0)) u64 (
    .clock(clock), .reset(reset), .enable(enable), .load(load), .data_valid(data_valid),
    .data(data), .setting_up(setting_up),
`ifdef COUNTER_MOD_DOWN_EN
    .setting_down(setting_down),
`endif
    .count(cnt_o[2]), .carry(car_o[2]), .at_max(max_o[2]));

  // Advance the reference model by one clock, then step past the edge.
  task automatic tick();
    bit down_on;
`ifdef COUNTER_MOD_DOWN_EN
    down_on = 1'b1;
`else
    down_on = 1'b0;
`endif
    for (int i = 0; i < 3; i++) begin
      int  m;
      bit  upe, dne;
      m   = mods[i];
      upe = setting_up && !m_upp[i];
      dne = down_on && setting_down && !m_dnp[i];
      if (reset) begin
        m_cnt[i] = inits[i];
        m_car[i] = 0;
        m_upp[i] = 0;
        m_dnp[i] = 0;
      end else begin
        m_car[i] = 0;
        if (load) begin
          if (data_valid)  m_cnt[i] = (int'(data) < m) ? int'(data) : m - 1;
          else if (upe)    m_cnt[i] = (m_cnt[i] + 1) % m;
          else if (dne)    m_cnt[i] = (m_cnt[i] + m - 1) % m;
        end else if (enable) begin
          if (m_cnt[i] + 1 == m) begin
            m_cnt[i] = 0;
            m_car[i] = 1;
          end else begin
            m_cnt[i] = m_cnt[i] + 1;
          end
        end
        m_upp[i] = setting_up;
        m_dnp[i] = setting_down;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    reset = 0; enable = 0; load = 0; data_valid = 0; data = '0;
    setting_up = 0; setting_down = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (cnt_o[i] !== 6'(inits[i]) || car_o[i] !== 1'b0 || max_o[i] !== 1'b0) begin
        n_fail++;
        $display("FAIL reset[%0d]: count=%0d carry=%b at_max=%b, want count=%0d carry=0 at_max=0",
                 i, cnt_o[i], car_o[i], max_o[i], inits[i]);
      end
    end
  endtask

  task automatic test_count();
    reset = 0;
    enable = 1;
    for (int k = 1; k <= 30; k++) begin
      tick();
      n_checks++;
      if (cnt_o[0] !== 6'(k % 24) || car_o[0] !== (k == 24) || max_o[0] !== ((k % 24) == 23)) begin
        n_fail++;
        $display("FAIL count_run k=%0d: count=%0d carry=%b at_max=%b, want count=%0d carry=%b at_max=%b",
                 k, cnt_o[0], car_o[0], max_o[0], k % 24, (k == 24), ((k % 24) == 23));
      end
    end
    enable = 0;
  endtask

  task automatic test_load();
    load = 1; data_valid = 1; data = 6'd17;
    tick();
    n_checks++;
    if (cnt_o[0] !== 6'd17 || car_o[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL load_17: count=%0d carry=%b, want 17 carry=0", cnt_o[0], car_o[0]);
    end
    data = 6'd40;
    tick();
    n_checks++;
    if (cnt_o[0] !== 6'd23 || car_o[0] !== 1'b0 || cnt_o[1] !== 6'd40) begin
      n_fail++;
      $display("FAIL load_clamp: count24=%0d carry=%b count60=%0d, want 23 carry=0 40",
               cnt_o[0], car_o[0], cnt_o[1]);
    end
    data_valid = 0;
  endtask

  task automatic test_buttons();
    load = 1; data_valid = 1; data = 6'd22;
    tick();
    data_valid = 0;
    setting_up = 1;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if (cnt_o[0] !== 6'd23 || car_o[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL button_hold k=%0d: count=%0d carry=%b, want 23 carry=0", k, cnt_o[0], car_o[0]);
      end
    end
    setting_up = 0;
    tick();
    setting_up = 1;
    tick();
    n_checks++;
    if (cnt_o[0] !== 6'd0 || car_o[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL button_wrap: count=%0d carry=%b, want 0 carry=0", cnt_o[0], car_o[0]);
    end
    setting_up = 0;
    tick();
  endtask

`ifdef COUNTER_MOD_DOWN_EN
  task automatic test_down();
    load = 1; data_valid = 1; data = 6'd0;
    tick();
    data_valid = 0;
    setting_down = 1;
    tick();
    setting_down = 0;
    n_checks++;
    if (cnt_o[0] !== 6'd23 || car_o[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL down_wrap: count=%0d carry=%b, want 23 carry=0", cnt_o[0], car_o[0]);
    end
    data_valid = 1; data = 6'd5;
    tick();
    data_valid = 0;
    setting_up = 1; setting_down = 1;
    tick();
    setting_up = 0; setting_down = 0;
    n_checks++;
    if (cnt_o[0] !== 6'd6) begin
      n_fail++;
      $display("FAIL up_beats_down: count=%0d, want 6", cnt_o[0]);
    end
    tick();
  endtask
`endif

  task automatic test_load_enable_reset();
    load = 1; data_valid = 1; data = 6'd23;
    tick();
    data_valid = 0;
    enable = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (cnt_o[0] !== 6'd23 || car_o[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL load_vs_enable k=%0d: count=%0d carry=%b, want 23 carry=0", k, cnt_o[0], car_o[0]);
      end
    end
    enable = 0; load = 0;
    tick();
    n_checks++;
    if (cnt_o[0] !== 6'd23 || car_o[0] !== 1'b0 || max_o[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL load_release: count=%0d carry=%b at_max=%b, want 23 carry=0 at_max=1",
               cnt_o[0], car_o[0], max_o[0]);
    end
    setting_up = 1; load = 1; enable = 1; reset = 1;
    tick();
    n_checks++;
    if (cnt_o[0] !== 6'd0 || car_o[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: count=%0d carry=%b, want 0 carry=0", cnt_o[0], car_o[0]);
    end
    reset = 0; enable = 0;
    tick();
    n_checks++;
    if (cnt_o[0] !== 6'd1) begin
      n_fail++;
      $display("FAIL step_after_reset: count=%0d, want 1", cnt_o[0]);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_sweep();
    int carries [3];
    idle_inputs();
    reset = 1;
    tick();
    reset = 0;
    enable = 1;
    carries = '{0, 0, 0};
    for (int k = 1; k <= 128; k++) begin
      tick();
      for (int i = 0; i < 3; i++) if (car_o[i] === 1'b1) carries[i]++;
      if (k == 63 || k == 64) begin
        n_checks++;
        if (cnt_o[2] !== 6'(k % 64) || car_o[2] !== (k == 64) || max_o[2] !== (k == 63)) begin
          n_fail++;
          $display("FAIL mod64_wrap k=%0d: count=%0d carry=%b at_max=%b, want %0d carry=%b at_max=%b",
                   k, cnt_o[2], car_o[2], max_o[2], k % 64, (k == 64), (k == 63));
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (carries[i] != (inits[i] + 128) / mods[i] || cnt_o[i] !== 6'((inits[i] + 128) % mods[i])) begin
        n_fail++;
        $display("FAIL sweep_mod%0d: carries=%0d count=%0d, want carries=%0d count=%0d", mods[i],
                 carries[i], cnt_o[i], (inits[i] + 128) / mods[i], (inits[i] + 128) % mods[i]);
      end
    end
    enable = 0;
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      reset      = ($urandom_range(0, 99) < 2);
      load       = ($urandom_range(0, 99) < 30);
      data_valid = ($urandom_range(0, 99) < 25);
      data       = 6'($urandom_range(0, 63));
      enable     = ($urandom_range(0, 99) < 65);
      if ($urandom_range(0, 99) < 35) setting_up = ~setting_up;
      if ($urandom_range(0, 99) < 35) setting_down = ~setting_down;
      tick();
      for (int i = 0; i < 3; i++) begin
        n_checks++;
        if (cnt_o[i] !== 6'(m_cnt[i]) || car_o[i] !== 1'(m_car[i]) ||
            max_o[i] !== (m_cnt[i] == mods[i] - 1)) begin
          n_fail++;
          $display("FAIL random k=%0d mod%0d: count=%0d carry=%b at_max=%b, want %0d carry=%0d at_max=%b",
                   k, mods[i], cnt_o[i], car_o[i], max_o[i], m_cnt[i], m_car[i], (m_cnt[i] == mods[i] - 1));
        end
      end
    end
    idle_inputs();
    tick();
  endtask

  initial begin
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      m_cnt[i] = 0; m_car[i] = 0; m_upp[i] = 0; m_dnp[i] = 0;
    end
    test_reset();
    test_count();
    test_load();
    test_buttons();
`ifdef COUNTER_MOD_DOWN_EN
    test_down();
`endif
    test_load_enable_reset();
    test_sweep();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
